// File: rtl/antares_multiplier_pkg.sv
// Shared definitions for the Antares multi-cycle multiplier: FSM states, accumulate modes
// and the iteration count shared with the divider.
package antares_multiplier_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE  = 2'd0,
        MULT_RUN   = 2'd1,
        MULT_FINAL = 2'd2
    } mult_state_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_e;

    localparam logic [4:0] MULT_ITER_COUNT = 5'd31;

endpackage

// File: rtl/antares_multiplier_if.sv
// Execute-stage bus between the pipeline (master) and the multiplier (slave).
interface antares_multiplier_if;

    logic        op_mults;
    logic        op_multu;
    logic        op_madds;
    logic        op_maddu;
    logic        op_msubs;
    logic        op_msubu;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] acc_in;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        mult_stall;

    modport master (
        output op_mults, op_multu, op_madds, op_maddu, op_msubs, op_msubu,
        output multiplicand, multiplier, acc_in,
        input  result_hi, result_lo, mult_stall
    );

    modport slave (
        input  op_mults, op_multu, op_madds, op_maddu, op_msubs, op_msubu,
        input  multiplicand, multiplier, acc_in,
        output result_hi, result_lo, mult_stall
    );

endinterface

// File: rtl/antares_cond_negate64.sv
// Conditional two's-complement negate; 64 bits by default, also instantiated at 32 bits.
module antares_cond_negate64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/antares_multiplier.sv
// Radix-2 shift-add 32x32->64 multiplier with sign fix in a final cycle and fixed 34-cycle latency.
// Build option ANTARES_MULT_ACCUM_EN enables the MADD/MSUB accumulate operations.
module antares_multiplier
    import antares_multiplier_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    antares_multiplier_if.slave bus
);

    mult_state_e state_r, state_nx_s;
    logic [4:0]  count_r;
    logic        neg_r;
    logic        stall_r;
    logic [31:0] mcand_r, mplier_r;
    logic [63:0] partial_r, product_r;

    logic        start_s, is_signed_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [32:0] sum_s;
    logic [64:0] shifted_s;
    logic [63:0] p_s, final_s;

`ifdef ANTARES_MULT_ACCUM_EN
    acc_mode_e   mode_s, mode_r;
    logic [63:0] acc_r;
`else
    logic        unused_s;
    assign unused_s = ^{bus.acc_in, bus.op_madds, bus.op_maddu, bus.op_msubs, bus.op_msubu};
`endif

    // Start decode with fixed priority mults > multu > madds > maddu > msubs > msubu
    always_comb begin
        start_s     = 1'b0;
        is_signed_s = 1'b0;
`ifdef ANTARES_MULT_ACCUM_EN
        mode_s      = ACC_NONE;
`endif
        if (bus.op_mults) begin
            start_s     = 1'b1;
            is_signed_s = 1'b1;
        end else if (bus.op_multu) begin
            start_s     = 1'b1;
`ifdef ANTARES_MULT_ACCUM_EN
        end else if (bus.op_madds) begin
            start_s     = 1'b1;
            is_signed_s = 1'b1;
            mode_s      = ACC_ADD;
        end else if (bus.op_maddu) begin
            start_s     = 1'b1;
            mode_s      = ACC_ADD;
        end else if (bus.op_msubs) begin
            start_s     = 1'b1;
            is_signed_s = 1'b1;
            mode_s      = ACC_SUB;
        end else if (bus.op_msubu) begin
            start_s     = 1'b1;
            mode_s      = ACC_SUB;
`endif
        end else begin
            start_s     = 1'b0;
        end
    end

    antares_cond_negate64 #(.WIDTH(32)) u_mag_a (
        .value  (bus.multiplicand),
        .negate (is_signed_s & bus.multiplicand[31]),
        .result (mag_a_s)
    );

    antares_cond_negate64 #(.WIDTH(32)) u_mag_b (
        .value  (bus.multiplier),
        .negate (is_signed_s & bus.multiplier[31]),
        .result (mag_b_s)
    );

    antares_cond_negate64 #(.WIDTH(64)) u_sign_fix (
        .value  (partial_r),
        .negate (neg_r),
        .result (p_s)
    );

    // One shift-add step: 33-bit add into the upper half, then shift carry and partial right
    always_comb begin
        sum_s     = {1'b0, partial_r[63:32]} + (mplier_r[0] ? {1'b0, mcand_r} : 33'd0);
        shifted_s = {sum_s, partial_r[31:0]};
    end

    // Final-cycle result selection
    always_comb begin
`ifdef ANTARES_MULT_ACCUM_EN
        case (mode_r)
            ACC_ADD: final_s = acc_r + p_s;
            ACC_SUB: final_s = acc_r - p_s;
            default: final_s = p_s;
        endcase
`else
        final_s = p_s;
`endif
    end

    // Next-state logic; a start op restarts from setup in any state
    always_comb begin
        state_nx_s = state_r;
        if (start_s) begin
            state_nx_s = MULT_RUN;
        end else begin
            case (state_r)
                MULT_IDLE:  state_nx_s = MULT_IDLE;
                MULT_RUN:   state_nx_s = (count_r == 5'd0) ? MULT_FINAL : MULT_RUN;
                MULT_FINAL: state_nx_s = MULT_IDLE;
                default:    state_nx_s = MULT_IDLE;
            endcase
        end
    end

    // State register and registered stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MULT_IDLE;
            stall_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            stall_r <= (state_nx_s != MULT_IDLE);
        end
    end

    // Datapath: setup latch, iteration, and product update in FINAL
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= 5'd0;
            neg_r     <= 1'b0;
            mcand_r   <= 32'd0;
            mplier_r  <= 32'd0;
            partial_r <= 64'd0;
            product_r <= 64'd0;
`ifdef ANTARES_MULT_ACCUM_EN
            acc_r     <= 64'd0;
            mode_r    <= ACC_NONE;
`endif
        end else if (start_s) begin
            count_r   <= MULT_ITER_COUNT;
            neg_r     <= is_signed_s & (bus.multiplicand[31] ^ bus.multiplier[31]);
            mcand_r   <= mag_a_s;
            mplier_r  <= mag_b_s;
            partial_r <= 64'd0;
`ifdef ANTARES_MULT_ACCUM_EN
            acc_r     <= bus.acc_in;
            mode_r    <= mode_s;
`endif
        end else begin
            case (state_r)
                MULT_RUN: begin
                    partial_r <= shifted_s[64:1];
                    mplier_r  <= {1'b0, mplier_r[31:1]};
                    if (count_r != 5'd0) begin
                        count_r <= count_r - 5'd1;
                    end
                end
                MULT_FINAL: product_r <= final_s;
                default: ;
            endcase
        end
    end

    assign bus.result_hi  = product_r[63:32];
    assign bus.result_lo  = product_r[31:0];
    assign bus.mult_stall = stall_r;

endmodule
